// File: rtl/addsub_result_stage_if.sv
// Handshake bundle between the add/sub unit, the result stage and its consumer.
// The stage itself uses the slave view; the producer/consumer side uses master.
interface addsub_result_stage_if #(
   parameter int OVF_CNT_W = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [3:0]           in_sum;
   logic                 in_cout;
   logic                 in_sub;
   logic                 in_a_msb;
   logic                 in_b_msb;
   logic                 out_valid;
   logic                 out_ready;
   logic [3:0]           out_sum;
   logic [3:0]           out_flags;
   logic [OVF_CNT_W-1:0] ovf_count;
   logic                 ovf_clr;

   modport slave (
      input  in_valid, in_sum, in_cout, in_sub, in_a_msb, in_b_msb,
      input  out_ready, ovf_clr,
      output in_ready, out_valid, out_sum, out_flags, ovf_count
   );

   modport master (
      output in_valid, in_sum, in_cout, in_sub, in_a_msb, in_b_msb,
      output out_ready, ovf_clr,
      input  in_ready, out_valid, out_sum, out_flags, ovf_count
   );
endinterface

// File: rtl/addsub_result_stage.sv
// Result stage after the 4-bit add/sub unit: derives N/Z/C/V, buffers {sum,flags}
// in a small FIFO towards the consumer and counts signed-overflow events.
module addsub_result_stage #(
   parameter int DEPTH     = 2,
   parameter int OVF_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   addsub_result_stage_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 8;

   function automatic logic [3:0] calc_flags(input logic [3:0] sum,
                                             input logic       cout,
                                             input logic       sub,
                                             input logic       a_msb,
                                             input logic       b_msb);
      logic n, z, c, v;
      n = sum[3];
      z = (sum == 4'd0);
      c = cout ^ sub;
      v = (a_msb == (b_msb ^ sub)) && (sum[3] != a_msb);
      return {n, z, c, v};
   endfunction

   function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + 1'b1;
   endfunction

   logic [AW:0]          r_wr_ptr;
   logic [AW:0]          r_rd_ptr;
   logic [EW-1:0]        r_mem [DEPTH];
   logic                 r_init;
   logic [OVF_CNT_W-1:0] r_ovf_cnt;

   logic                 w_empty;
   logic                 w_full;
   logic                 w_in_ready;
   logic                 w_push;
   logic                 w_pop;
   logic [3:0]           w_flags;
   logic [EW-1:0]        w_head;

   // Input side: flags are derived combinationally and stored with the sum
   assign w_flags    = calc_flags(bus.in_sum, bus.in_cout, bus.in_sub,
                                  bus.in_a_msb, bus.in_b_msb);
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_in_ready = r_init && !w_full;
   assign w_push     = bus.in_valid && w_in_ready;
   assign w_pop      = !w_empty && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_init    <= 1'b0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_ovf_cnt <= '0;
      end else begin
         r_init <= 1'b1;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (bus.ovf_clr)
            r_ovf_cnt <= '0;
         else if (w_push && w_flags[0])
            r_ovf_cnt <= sat_inc(r_ovf_cnt);
      end
   end

   // Storage holds data only; validity is carried entirely by the pointers
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {bus.in_sum, w_flags};
   end

   // Output side: head entry is gated to zero whenever nothing is valid
   assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = !w_empty;
   assign bus.out_sum   = w_empty ? 4'd0 : w_head[7:4];
   assign bus.out_flags = w_empty ? 4'd0 : w_head[3:0];
   assign bus.ovf_count = r_ovf_cnt;

endmodule

// File: tb/tb_addsub_result_stage.sv
// Bench for addsub_result_stage: fixed vectors, FIFO corner sequences and a
// randomized run against an arithmetic reference model.
module tb_addsub_result_stage;
   localparam int DEPTH     = 2;
   localparam int OVF_CNT_W = 8;
   localparam int OVF_MAX   = (1 << OVF_CNT_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   addsub_result_stage_if #(.OVF_CNT_W(OVF_CNT_W)) bus ();

   addsub_result_stage #(.DEPTH(DEPTH), .OVF_CNT_W(OVF_CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] sum;
      logic       cout;
      logic       sub;
      logic       am;
      logic       bm;
      logic [3:0] flags;
      int         ovf;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_raw(input logic [3:0] s, input logic c, input logic sub,
                            input logic am, input logic bm);
      bus.in_sum   = s;
      bus.in_cout  = c;
      bus.in_sub   = sub;
      bus.in_a_msb = am;
      bus.in_b_msb = bm;
   endtask

   function automatic int sext4(input int x);
      return (x >= 8) ? x - 16 : x;
   endfunction

   function automatic logic [3:0] ref_sum(input int a, input int b, input bit sub);
      int u;
      u = sub ? a - b : a + b;
      return 4'(u & 15);
   endfunction

   // Flags from the arithmetic meaning of the operation, not from bit tricks
   function automatic logic [3:0] ref_flags(input int a, input int b, input bit sub);
      int u, s, r;
      logic n, z, c, v;
      u = sub ? a - b : a + b;
      s = sub ? sext4(a) - sext4(b) : sext4(a) + sext4(b);
      r = u & 15;
      n = (r >= 8);
      z = (r == 0);
      c = sub ? (a < b) : (u > 15);
      v = (s > 7) || (s < -8);
      return {n, z, c, v};
   endfunction

   task automatic drive_ab(input int a, input int b, input bit sub);
      bus.in_sum   = ref_sum(a, b, sub);
      bus.in_cout  = sub ? (a >= b) : ((a + b) > 15);
      bus.in_sub   = sub;
      bus.in_a_msb = (a >= 8);
      bus.in_b_msb = (b >= 8);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [3:0] expq [$];
      logic [3:0] q_sum [$];
      logic [3:0] q_flg [$];
      int         nxt, pops, mcnt, a, b;
      bit         sub, hold, acc, pop, rdy, ov;
      logic [3:0] os, fl;

      vecs[0] = '{4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0};
      vecs[1] = '{4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 1};
      vecs[2] = '{4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1};
      vecs[3] = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 1};
      vecs[4] = '{4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0111, 2};
      vecs[5] = '{4'h7, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 3};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.ovf_clr   = 1'b0;
      drive_raw(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset state
      #2 rst_n = 1'b0;
      #20;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_sum",   32'(bus.out_sum),   32'd0);
      chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
      chk("rst_ovf_count", 32'(bus.ovf_count), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Fixed vectors: one push each, visible next cycle, popped the cycle after
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive_raw(vecs[i].sum, vecs[i].cout, vecs[i].sub, vecs[i].am, vecs[i].bm);
         bus.in_valid = 1'b1;
         step();
         bus.in_valid = 1'b0;
         chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
         chk($sformatf("vec%0d_sum", i),   32'(bus.out_sum),   32'(vecs[i].sum));
         chk($sformatf("vec%0d_flags", i), 32'(bus.out_flags), 32'(vecs[i].flags));
         chk($sformatf("vec%0d_ovf", i),   32'(bus.ovf_count), 32'(vecs[i].ovf));
         step();
         chk($sformatf("vec%0d_drained", i), 32'(bus.out_valid), 32'd0);
      end

      // Fill with consumer stalled, extra input ignored, then drain in order
      bus.out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drive_raw(4'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
         bus.in_valid = 1'b1;
         step();
      end
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      drive_raw(4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("full_ignore_in_ready", 32'(bus.in_ready), 32'd0);
      chk("full_hold_sum", 32'(bus.out_sum), 32'd1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk($sformatf("drain%0d_valid", i), 32'(bus.out_valid), 32'd1);
         chk($sformatf("drain%0d_sum", i),   32'(bus.out_sum),   32'(i + 1));
         step();
         if (i == 0) chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
      end
      chk("drain_empty", 32'(bus.out_valid), 32'd0);

      // Full FIFO with producer and consumer both active for 10 cycles
      nxt = 1;
      bus.out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drive_raw(4'(nxt), 1'b0, 1'b0, 1'b0, 1'b0);
         bus.in_valid = 1'b1;
         expq.push_back(4'(nxt));
         nxt++;
         step();
      end
      pops = 0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_raw(4'(nxt & 15), 1'b0, 1'b0, 1'b0, 1'b0);
         rdy = bus.in_ready;
         ov  = bus.out_valid;
         os  = bus.out_sum;
         chk($sformatf("stream%0d_valid", i), 32'(ov), 32'd1);
         if (ov && expq.size() > 0) begin
            chk($sformatf("stream%0d_sum", i), 32'(os), 32'(expq.pop_front()));
            pops++;
         end
         if (rdy) begin
            expq.push_back(4'(nxt & 15));
            nxt++;
         end
         step();
      end
      bus.in_valid = 1'b0;
      chk("stream_pops", 32'(pops), 32'd10);
      for (int i = 0; i < DEPTH + 1 && expq.size() > 0; i++) begin
         chk("stream_tail_sum", 32'(bus.out_sum), 32'(expq.pop_front()));
         step();
      end
      chk("stream_empty", 32'(bus.out_valid), 32'd0);

      // Randomized traffic against the reference model
      bus.ovf_clr = 1'b1;
      step();
      bus.ovf_clr = 1'b0;
      mcnt = 0;
      hold = 0;
      a = 0; b = 0; sub = 0;
      for (int n = 0; n < 500; n++) begin
         chk("rnd_out_valid", 32'(bus.out_valid), 32'(q_sum.size() > 0));
         chk("rnd_in_ready",  32'(bus.in_ready),  32'(q_sum.size() < DEPTH));
         chk("rnd_ovf_count", 32'(bus.ovf_count), 32'(mcnt));
         if (q_sum.size() > 0) begin
            chk("rnd_out_sum",   32'(bus.out_sum),   32'(q_sum[0]));
            chk("rnd_out_flags", 32'(bus.out_flags), 32'(q_flg[0]));
         end
         if (!hold) begin
            a   = $urandom_range(0, 15);
            b   = $urandom_range(0, 15);
            sub = 1'($urandom_range(0, 1));
            bus.in_valid = ($urandom_range(0, 3) != 0);
         end
         drive_ab(a, b, sub);
         bus.out_ready = ($urandom_range(0, 1) != 0);
         bus.ovf_clr   = ($urandom_range(0, 15) == 0);
         acc = bus.in_valid && (q_sum.size() < DEPTH);
         pop = (q_sum.size() > 0) && bus.out_ready;
         fl  = ref_flags(a, b, sub);
         step();
         if (pop) begin
            void'(q_sum.pop_front());
            void'(q_flg.pop_front());
         end
         if (acc) begin
            q_sum.push_back(ref_sum(a, b, sub));
            q_flg.push_back(fl);
         end
         if (bus.ovf_clr) mcnt = 0;
         else if (acc && fl[0] && mcnt < OVF_MAX) mcnt++;
         hold = bus.in_valid && !acc;
      end
      bus.in_valid = 1'b0;
      bus.ovf_clr  = 1'b0;

      // Overflow counter saturation, clear priority, asynchronous reset
      bus.out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) step();
      bus.ovf_clr = 1'b1;
      step();
      bus.ovf_clr = 1'b0;
      chk("sat_start", 32'(bus.ovf_count), 32'd0);
      drive_ab(7, 1, 1'b0);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 300; i++) step();
      chk("sat_count", 32'(bus.ovf_count), 32'(OVF_MAX));
      bus.ovf_clr = 1'b1;
      step();
      bus.ovf_clr = 1'b0;
      chk("clr_priority", 32'(bus.ovf_count), 32'd0);
      bus.out_ready = 1'b0;
      step();
      chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("async_rst_sum",   32'(bus.out_sum),   32'd0);
      chk("async_rst_flags", 32'(bus.out_flags), 32'd0);
      chk("async_rst_ovf",   32'(bus.ovf_count), 32'd0);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("post_rst_in_ready", 32'(bus.in_ready),  32'd1);
      chk("post_rst_valid",    32'(bus.out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/addsub_result_stage.md
Name: addsub_result_stage

Overview:
Registered output stage directly downstream of the 4-bit add/subtract unit. It captures each 4-bit result, together with the carry-out and the operand sign bits, and derives the N/Z/C/V status flags. Results are buffered in a 2-entry FIFO and handed to the consumer (display/ALU register file) over a valid/ready handshake. A saturating counter tracks signed-overflow events.

Parameters:
DEPTH, 2, FIFO entries; legal values 2 or 4 (power of two).
OVF_CNT_W, 8, width of the overflow event counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer presents a result this cycle
in_ready  output  1  stage can accept; transfer occurs when in_valid && in_ready
in_sum  input  4  sum[3:0] from the add/sub unit
in_cout  input  1  carry-out from the add/sub unit
in_sub  input  1  operation select: 1 = subtract (A - B), 0 = add
in_a_msb  input  1  A[3]
in_b_msb  input  1  raw B[3], before inversion
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts; pop occurs when out_valid && out_ready
out_sum  output  4  head entry result
out_flags  output  4  {N,Z,C,V} of head entry
ovf_count  output  OVF_CNT_W  saturating count of accepted entries with V=1
ovf_clr  input  1  synchronous clear of ovf_count

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty; out_valid=0; out_sum=0; out_flags=0; ovf_count=0; in_ready=1 one cycle after release.
- Flag computation is combinational on the input side and stored with the entry:
  - N = in_sum[3].
  - Z = (in_sum == 0).
  - C = in_cout when in_sub=0; C = ~in_cout (borrow) when in_sub=1.
  - V = (in_a_msb == (in_b_msb ^ in_sub)) && (in_sum[3] != in_a_msb).
- Push: in_valid && in_ready writes {sum, flags} at the write pointer.
- Pop: out_valid && out_ready advances the read pointer.
- Pointers are log2(DEPTH)+1 bits wide and wrap naturally.
  - empty = pointers equal.
  - full = MSBs differ and the rest are equal.
- in_ready = !full. It is a registered-state function only and does not depend combinationally on out_ready.
- out_valid = !empty. out_sum/out_flags are the head entry, read combinationally from the storage array.
- Latency: an entry pushed in cycle T is visible on the outputs in cycle T+1.
- Simultaneous push and pop:
  - When not empty: both occur and occupancy is unchanged.
  - When empty: only the push occurs; no bypass.
  - When full: in_ready=0, so only the pop occurs. The slot is reusable the next cycle.
- Output stability: while out_valid=1 and out_ready=0, out_sum/out_flags hold steady.
- in_valid && !in_ready: the input is ignored. The producer must hold it.
- ovf_count:
  - Increments by 1 on each push with V=1.
  - Saturates at all-ones and does not wrap.
  - ovf_clr takes priority over an increment in the same cycle; the result is 0.
- rst_n asserted mid-operation: all entries are discarded immediately and outputs return to reset values asynchronously.
- No X propagation: unused storage is don't-care but is never presented while out_valid=1.

Test Plan:
1. Add, in_sum=4'h7, cout=0, a_msb=0, b_msb=0, sub=0, out_ready=1 -> next cycle out_valid=1, out_sum=7, flags N0 Z0 C0 V0; ovf_count=0.
2. Add 7+1 giving sum=4'h8, cout=0, a_msb=0, b_msb=0, sub=0 -> flags N1 Z0 C0 V1; ovf_count=1.
3. Subtract 5-5 giving sum=0, cout=1, a_msb=0, b_msb=0, sub=1 -> flags N0 Z1 C0 V0. Subtract 2-3 giving sum=4'hF, cout=0 -> flags N1 Z0 C1 V0.
4. Hold out_ready=0 and push DEPTH entries -> in_ready drops to 0 after the DEPTH-th push and a further in_valid is ignored. Raise out_ready -> entries drain in push order, and in_ready=1 the cycle after the first pop.
5. Keep full and assert in_valid and out_ready continuously for 10 cycles -> one entry out per cycle, order preserved, no loss or duplication.
6. Force 300 overflow pushes with OVF_CNT_W=8 -> ovf_count saturates at 255. Assert ovf_clr with a V=1 push in the same cycle -> 0. Assert rst_n low mid-stream -> out_valid=0 immediately.
